ppi_bus_master: RTL and testbench



---
 rtl/ppi_pkg.sv | 36 +++
 rtl/ppi_phase_counter.sv | 42 ++++
 rtl/ppi_bus_master.sv | 189 ++++++++++++++++++
 tb/tb_ppi_bus_master.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared types and constants for the PPI bus master
//
// Purpose: FSM state encoding, PPI register addresses and 8255 control-word
//          bit positions used by ppi_bus_master and its sub-modules.
// Ports:   none (package).

package ppi_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } ppi_state_e;

   localparam logic [1:0] PPI_ADDR_PA   = 2'b00;
   localparam logic [1:0] PPI_ADDR_PB   = 2'b01;
   localparam logic [1:0] PPI_ADDR_PC   = 2'b10;
   localparam logic [1:0] PPI_ADDR_CTRL = 2'b11;

   // Control word layout (mode-set form, bit 7 = 1)
   localparam int unsigned PPI_CW_MODE_SET    = 7;
   localparam int unsigned PPI_CW_GA_MODE_MSB = 6;
   localparam int unsigned PPI_CW_GA_MODE_LSB = 5;
   localparam int unsigned PPI_CW_PA_DIR      = 4;
   localparam int unsigned PPI_CW_PCU_DIR     = 3;
   localparam int unsigned PPI_CW_GB_MODE     = 2;
   localparam int unsigned PPI_CW_PB_DIR      = 1;
   localparam int unsigned PPI_CW_PCL_DIR     = 0;

   function automatic logic ppi_cw_is_mode_set(input logic [7:0] cw);
      return cw[PPI_CW_MODE_SET];
   endfunction

endpackage

// File: rtl/ppi_phase_counter.sv
// rtl/ppi_phase_counter.sv - down counter timing one bus phase
//
// Purpose: loads (phase length - 1) when a phase is entered and counts down
//          to zero, saturating there; last_o marks the final phase cycle.
// Ports:   clk_i, rst_ni   clock and asynchronous active-low reset
//          load_i          load load_val_i this cycle (phase entry)
//          load_val_i      value to load
//          last_o          high while the count is zero

module ppi_phase_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// rtl/ppi_bus_master.sv - CPU-side initiator generating 8255-style bus cycles
//
// Purpose: accepts single read/write commands and runs a SETUP / STROBE / HOLD
//          bus cycle on A, cs_n, rd_n, wr_n and DATA, then pulses rsp_valid.
// Ports:   clk, rst_n                clock, asynchronous active-low reset
//          cmd_valid/cmd_ready       command handshake
//          cmd_write/addr/wdata      command fields, latched on accept
//          rsp_valid/rsp_rdata       completion pulse and read data
//          busy                      FSM not idle
//          A, cs_n, rd_n, wr_n, DATA PPI bus
//          ctrl_shadow               last control word written (option only)
// Option:  PPI_BUS_MASTER_CTRL_SHADOW_EN keeps a copy of the control word and
//          answers control reads from it without a bus cycle.

module ppi_bus_master
   import ppi_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1,
   parameter int unsigned CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [1:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic [1:0] A,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
`ifdef PPI_BUS_MASTER_CTRL_SHADOW_EN
   output logic [7:0] ctrl_shadow,
`endif
   inout  wire  [7:0] DATA
);

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

   ppi_state_e       state_q;
   ppi_state_e       state_d;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_last;

   logic             write_q;
   logic [1:0]       addr_q;
   logic [7:0]       wdata_q;
   logic [7:0]       rdata_q;
   logic [7:0]       rsp_rdata_q;

   logic             accept;
   logic             short_rd;
   logic             bus_phase;
   logic             phase_end;

   // Ready is gated by rst_n so it reads low for the whole reset window.
   assign cmd_ready = rst_n && (state_q == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign phase_end = (state_q == HOLD) && cnt_last;

`ifdef PPI_BUS_MASTER_CTRL_SHADOW_EN
   logic [7:0] shadow_q;

   // Control reads are answered from the shadow and skip the bus entirely.
   assign short_rd    = !cmd_write && (cmd_addr == PPI_ADDR_CTRL);
   assign ctrl_shadow = shadow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= 8'h00;
      end else if (phase_end && write_q && (addr_q == PPI_ADDR_CTRL)) begin
         shadow_q <= wdata_q;
      end
   end
`else
   assign short_rd = 1'b0;
`endif

   ppi_phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase_cnt (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .last_o     (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (short_rd) begin
                  state_d = DONE;
               end else begin
                  state_d      = SETUP;
                  cnt_load     = 1'b1;
                  cnt_load_val = SETUP_LD;
               end
            end
         end
         SETUP: begin
            if (cnt_last) begin
               state_d      = STROBE;
               cnt_load     = 1'b1;
               cnt_load_val = STROBE_LD;
            end
         end
         STROBE: begin
            if (cnt_last) begin
               state_d      = HOLD;
               cnt_load     = 1'b1;
               cnt_load_val = HOLD_LD;
            end
         end
         HOLD: begin
            if (cnt_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q     <= 1'b0;
         addr_q      <= PPI_ADDR_PA;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         rsp_rdata_q <= 8'h00;
      end else begin
         if (accept) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
`ifdef PPI_BUS_MASTER_CTRL_SHADOW_EN
            if (short_rd) begin
               rsp_rdata_q <= shadow_q;
            end
`endif
         end
         // Sample on the edge that closes the last strobe cycle.
         if ((state_q == STROBE) && cnt_last && !write_q) begin
            rdata_q <= DATA;
         end
         // Response data changes only when a command completes.
         if (phase_end) begin
            rsp_rdata_q <= write_q ? 8'h00 : rdata_q;
         end
      end
   end

   assign bus_phase = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);

   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_rdata = rsp_rdata_q;
   assign cs_n      = !bus_phase;
   assign A         = bus_phase ? addr_q : PPI_ADDR_PA;
   assign rd_n      = !((state_q == STROBE) && !write_q);
   assign wr_n      = !((state_q == STROBE) && write_q);
   assign DATA      = (bus_phase && write_q) ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb/tb_ppi_bus_master.sv - self-checking bench for ppi_bus_master

module tb_ppi_bus_master;

   localparam int S = 1;
   localparam int T = 2;
   localparam int H = 1;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_write = 1'b0;
   logic [1:0] cmd_addr  = 2'b00;
   logic [7:0] cmd_wdata = 8'h00;
   wire        cmd_ready;
   wire        rsp_valid;
   wire  [7:0] rsp_rdata;
   wire        busy;
   wire  [1:0] A;
   wire        cs_n;
   wire        rd_n;
   wire        wr_n;
   wire  [7:0] DATA;
`ifdef PPI_BUS_MASTER_CTRL_SHADOW_EN
   wire  [7:0] ctrl_shadow;
`endif

   logic       tb_drv = 1'b0;
   logic [7:0] tb_val = 8'h00;
   logic [7:0] rd_val = 8'h00;

   assign DATA = tb_drv ? tb_val : 8'hzz;

   always #5 clk = ~clk;

   ppi_bus_master #(
      .SETUP_CYC  (S),
      .STROBE_CYC (T),
      .HOLD_CYC   (H),
      .CNT_W      (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .busy        (busy),
      .A           (A),
      .cs_n        (cs_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
`ifdef PPI_BUS_MASTER_CTRL_SHADOW_EN
      .ctrl_shadow (ctrl_shadow),
`endif
      .DATA        (DATA)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: one active command, k = cycles since its accept edge.
   bit         m_active = 1'b0;
   bit         m_write  = 1'b0;
   bit         m_short  = 1'b0;
   logic [1:0] m_addr   = 2'b00;
   logic [7:0] m_wdata  = 8'h00;
   logic [7:0] m_rval   = 8'h00;
   logic [7:0] m_rsp    = 8'h00;
   logic [7:0] m_shadow = 8'h00;
   int         m_k      = 0;
   int         m_d      = 0;
   int         m_acc    = 0;

   function automatic bit is_short(input logic w, input logic [1:0] a);
`ifdef PPI_BUS_MASTER_CTRL_SHADOW_EN
      return !w && (a == 2'b11);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_rsp    <= 8'h00;
         m_shadow <= 8'h00;
      end else if (m_active) begin
         if (m_k == m_d) begin
            m_active <= 1'b0;
         end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_d) begin
               m_rsp <= m_write ? 8'h00 : m_rval;
               if (m_write && m_addr == 2'b11) m_shadow <= m_wdata;
            end
         end
      end else if (cmd_valid) begin
         m_active <= 1'b1;
         m_k      <= 1;
         m_write  <= cmd_write;
         m_addr   <= cmd_addr;
         m_wdata  <= cmd_wdata;
         m_rval   <= rd_val;
         m_acc    <= m_acc + 1;
         if (is_short(cmd_write, cmd_addr)) begin
            m_short <= 1'b1;
            m_d     <= 1;
            m_rsp   <= m_shadow;
         end else begin
            m_short <= 1'b0;
            m_d     <= S + T + H + 1;
         end
      end
   end

   // Peripheral side: drive the expected value only while rd_n is low,
   // junk otherwise, so a mistimed sample returns the wrong byte.
   initial begin
      forever begin
         @(negedge clk);
         tb_drv = m_active && !m_write && !m_short;
         tb_val = (!rd_n) ? m_rval : 8'($urandom);
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial begin
      bit bus;
      bit strb;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_cs_n", cs_n, 1);
            chk("rst_rd_n", rd_n, 1);
            chk("rst_wr_n", wr_n, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ready", cmd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_A", A, 0);
         end else begin
            bus  = m_active && !m_short && (m_k <= S + T + H);
            strb = m_active && !m_short && (m_k > S) && (m_k <= S + T);
            chk("cs_n", cs_n, !bus);
            chk("rd_n", rd_n, !(strb && !m_write));
            chk("wr_n", wr_n, !(strb && m_write));
            chk("busy", busy, m_active);
            chk("cmd_ready", cmd_ready, !m_active);
            chk("rsp_valid", rsp_valid, m_active && (m_k == m_d));
            chk("rsp_rdata", rsp_rdata, m_rsp);
            if (bus) chk("A", A, m_addr);
            if (bus && m_write) chk("DATA", DATA, m_wdata);
         end
`ifdef PPI_BUS_MASTER_CTRL_SHADOW_EN
         chk("ctrl_shadow", ctrl_shadow, m_shadow);
`endif
      end
   end

   task automatic issue(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] rv, input bit keep, output int edges);
      int c0;
      bit got;
      c0        = m_acc;
      rd_val    = rv;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      got       = 1'b0;
      edges     = 0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(posedge clk);
         #2;
         if (m_acc != c0) begin
            got   = 1'b1;
            edges = i;
         end
      end
      chk("accept_timeout", got, 1);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic measure(input bit chkdata, input logic [7:0] dexp,
                          output int lat, output int ncs, output int nrd,
                          output int nwr, output int ndbad);
      lat = -1; ncs = 0; nrd = 0; nwr = 0; ndbad = 0;
      for (int i = 1; i <= 30 && lat < 0; i++) begin
         @(negedge clk);
         if (!cs_n) ncs++;
         if (!rd_n) nrd++;
         if (!wr_n) nwr++;
         if (chkdata && !cs_n && DATA !== dexp) ndbad++;
         if (rsp_valid) lat = i;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk);
         #2;
         ok = !m_active;
      end
      chk("idle_timeout", ok, 1);
   endtask

   initial begin
      int e, lat, ncs, nrd, nwr, nbad, c0;

      #22 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rdata", rsp_rdata, 0);

      // 1: control word write
      issue(1'b1, 2'b11, 8'h9B, 8'h00, 1'b0, e);
      measure(1'b1, 8'h9B, lat, ncs, nrd, nwr, nbad);
      chk("t1_latency", lat, 5);
      chk("t1_cs_cycles", ncs, 4);
      chk("t1_wr_cycles", nwr, 2);
      chk("t1_rd_cycles", nrd, 0);
      chk("t1_data_bad", nbad, 0);
      chk("t1_rdata", rsp_rdata, 8'h00);

      // 2: read Port A
      issue(1'b0, 2'b00, 8'h00, 8'hFF, 1'b0, e);
      measure(1'b0, 8'h00, lat, ncs, nrd, nwr, nbad);
      chk("t2_latency", lat, 5);
      chk("t2_rd_cycles", nrd, 2);
      chk("t2_wr_cycles", nwr, 0);
      chk("t2_rdata", rsp_rdata, 8'hFF);

      // 3: back-to-back write Port B, read Port C
      issue(1'b1, 2'b01, 8'h09, 8'h00, 1'b0, e);
      measure(1'b1, 8'h09, lat, ncs, nrd, nwr, nbad);
      chk("t3_wr_latency", lat, 5);
      issue(1'b0, 2'b10, 8'h00, 8'h03, 1'b0, e);
      chk("t3_accept_gap_edges", e, 2);
      measure(1'b0, 8'h00, lat, ncs, nrd, nwr, nbad);
      chk("t3_rdata", rsp_rdata, 8'h03);

      // 4: cmd_valid held with changing fields during a transfer
      wait_idle();
      c0 = m_acc;
      issue(1'b1, 2'b10, 8'h5C, 8'h00, 1'b1, e);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i <= 4) chk("t4_A_held", A, 2'b10);
         chk("t4_ready", cmd_ready, (i == 6));
         cmd_addr  = 2'($urandom);
         cmd_write = 1'($urandom);
         cmd_wdata = 8'($urandom);
         if (i == 6) cmd_valid = 1'b0;
      end
      chk("t4_single_accept", m_acc - c0, 1);
      wait_idle();

      // 5: reset in the middle of a write strobe
      issue(1'b1, 2'b01, 8'hA5, 8'h00, 1'b0, e);
      @(posedge clk);
      #2;
      chk("t5_in_strobe", wr_n, 0);
      rst_n = 1'b0;
      #1;
      chk("t5_async_wr_n", wr_n, 1);
      chk("t5_async_cs_n", cs_n, 1);
      chk("t5_async_busy", busy, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      issue(1'b0, 2'b00, 8'h00, 8'h08, 1'b0, e);
      measure(1'b0, 8'h00, lat, ncs, nrd, nwr, nbad);
      chk("t5_latency", lat, 5);
      chk("t5_rdata", rsp_rdata, 8'h08);

      // 6: control read
      issue(1'b1, 2'b11, 8'h9B, 8'h00, 1'b0, e);
      measure(1'b1, 8'h9B, lat, ncs, nrd, nwr, nbad);
      issue(1'b0, 2'b11, 8'h00, 8'h5A, 1'b0, e);
      measure(1'b0, 8'h00, lat, ncs, nrd, nwr, nbad);
`ifdef PPI_BUS_MASTER_CTRL_SHADOW_EN
      chk("t6_latency", lat, 1);
      chk("t6_cs_cycles", ncs, 0);
      chk("t6_rdata", rsp_rdata, 8'h9B);
      chk("t6_shadow", ctrl_shadow, 8'h9B);
`else
      chk("t6_latency", lat, 5);
      chk("t6_rd_cycles", nrd, 2);
      chk("t6_rdata", rsp_rdata, 8'h5A);
`endif

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #2;
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_write = 1'($urandom);
         cmd_addr  = 2'($urandom);
         cmd_wdata = 8'($urandom);
         rd_val    = 8'($urandom);
      end
      cmd_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1, "watchdog");
   end

endmodule
